fwd_hazard_unit: RTL and testbench

- Generates the operand-forwarding select codes consumed by the EX-stage 3-to-1 operand muxes (A and B) of the DLX pipeline.
- Detects load-use hazards and requests a one-cycle stall.
- Tracks ID/EX, EX/MEM and MEM/WB destination metadata internally, so selects are registered and arrive with the instruction entering EX.

---
 rtl/fwd_hazard_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//
// Operand-forwarding and load-use hazard unit for the DLX five-stage pipeline.
// The unit keeps its own copy of the destination metadata held by the ID/EX, EX/MEM and
// MEM/WB pipeline registers. It computes the EX-stage operand selects while the consumer is
// still in ID and registers them, so the selects reach EX in the same cycle as the
// instruction.
//
// Ports
//   clk          pipeline clock
//   reset_n      asynchronous active-low reset
//   freeze       global pipeline freeze; every register holds, including the selects
//   flush        squash; the instruction leaving ID becomes a bubble
//   id_valid     ID holds a real instruction
//   id_rs/id_rt  ID source registers, qualified by id_uses_rs/id_uses_rt
//   id_rd        ID destination register, qualified by id_regwrite
//   id_memread   ID instruction is a load
//   stall        combinational load-use hazard; upstream holds PC and IF/ID
//   fwd_a_sel    EX operand A mux select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
//   fwd_b_sel    EX operand B mux select, same encoding
//   ex_valid     EX holds a real instruction
//   stall_count  saturating count of load-use stall cycles
//
// Configuration
//   FWD_STALL_CNT_EN  when defined, stall_count counts the stall cycles that are not frozen
//                     and saturates at 16'hFFFF. When undefined, stall_count is tied to zero
//                     and the design contains no counter.

module fwd_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  output logic                  stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  ex_valid,
  output logic [15:0]           stall_count
);

  // Select encodings for the EX operand muxes.
  localparam logic [1:0] SelRegfile = 2'b00;
  localparam logic [1:0] SelExMem   = 2'b10;
  localparam logic [1:0] SelMemWb   = 2'b01;

  // ---------------------------------------------------------------------------------------
  // Pipeline metadata
  // ---------------------------------------------------------------------------------------
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } idex_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } stage_t;

  idex_t      idex_q,  idex_d;
  stage_t     exmem_q, exmem_d;
  stage_t     memwb_q, memwb_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  // ---------------------------------------------------------------------------------------
  // Forwarding select for one source operand
  // ---------------------------------------------------------------------------------------
  // The producer currently in ID/EX will sit in EX/MEM once the consumer reaches EX, so it
  // maps to the EX/MEM select. The producer in EX/MEM maps to MEM/WB in the same way. The
  // ID/EX producer is newer and takes priority. Anything older has already been written back
  // by the time the consumer reads the register file.
  function automatic logic [1:0] calc_sel(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] src,
    input idex_t                 idex,
    input stage_t                exmem
  );
    logic src_live;
    src_live = uses && (src != '0);
    if (src_live && idex.valid && idex.regwrite && (idex.rd == src)) begin
      return SelExMem;
    end else if (src_live && exmem.valid && exmem.regwrite && (exmem.rd == src)) begin
      return SelMemWb;
    end else begin
      return SelRegfile;
    end
  endfunction

  logic [1:0] sel_a_new;
  logic [1:0] sel_b_new;

  always_comb begin
    sel_a_new = SelRegfile;
    sel_b_new = SelRegfile;
    if (id_valid) begin
      sel_a_new = calc_sel(id_uses_rs, id_rs, idex_q, exmem_q);
      sel_b_new = calc_sel(id_uses_rt, id_rt, idex_q, exmem_q);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------------------------
  // A load result is only available from MEM/WB. A consumer directly behind the load must
  // wait one cycle. A squashed consumer never stalls.
  logic load_rs_hit;
  logic load_rt_hit;
  logic load_in_ex;

  assign load_in_ex  = idex_q.valid && idex_q.memread && (idex_q.rd != '0);
  assign load_rs_hit = id_uses_rs && (id_rs == idex_q.rd);
  assign load_rt_hit = id_uses_rt && (id_rt == idex_q.rd);

  assign stall = id_valid && load_in_ex && (load_rs_hit || load_rt_hit) && !flush;

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;

    if (!freeze) begin
      memwb_d.valid    = exmem_q.valid;
      memwb_d.rd       = exmem_q.rd;
      memwb_d.regwrite = exmem_q.regwrite;

      exmem_d.valid    = idex_q.valid;
      exmem_d.rd       = idex_q.rd;
      exmem_d.regwrite = idex_q.regwrite;

      if (flush || stall) begin
        // Bubble into EX: nothing to forward to it and nothing it produces.
        idex_d.valid    = 1'b0;
        idex_d.rd       = '0;
        idex_d.regwrite = 1'b0;
        idex_d.memread  = 1'b0;
        fwd_a_d         = SelRegfile;
        fwd_b_d         = SelRegfile;
      end else begin
        idex_d.valid    = id_valid;
        idex_d.rd       = id_rd;
        idex_d.regwrite = id_regwrite;
        idex_d.memread  = id_memread;
        fwd_a_d         = sel_a_new;
        fwd_b_d         = sel_b_new;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      fwd_a_q <= SelRegfile;
      fwd_b_q <= SelRegfile;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign ex_valid  = idex_q.valid;

  // MEM/WB is tracked so the unit mirrors the datapath. Its result reaches consumers through
  // the register file's write-before-read, so it never drives a select.
  logic unused_memwb;
  assign unused_memwb = ^memwb_q;

  // ---------------------------------------------------------------------------------------
  // Optional load-use stall counter
  // ---------------------------------------------------------------------------------------
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !freeze && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

  // ---------------------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------------------
  sel_a_legal: assert property (@(posedge clk) disable iff (!reset_n) fwd_a_sel != 2'b11);
  sel_b_legal: assert property (@(posedge clk) disable iff (!reset_n) fwd_b_sel != 2'b11);
  stall_needs_load: assert property (@(posedge clk) disable iff (!reset_n)
                                     stall |-> (idex_q.valid && idex_q.memread));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk;
  logic       reset_n;
  logic       freeze;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       ex_valid;
  logic [15:0] stall_count;

  int checks;
  int errors;

`ifdef FWD_STALL_CNT_EN
  localparam bit CntOn = 1'b1;
`else
  localparam bit CntOn = 1'b0;
`endif

  fwd_hazard_unit #(.REG_ADDR_W(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .freeze      (freeze),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .stall       (stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .ex_valid    (ex_valid),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction in ID.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    freeze  = 1'b0;
    flush   = 1'b0;
    nop();
    #2;
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_sel: got a=%b b=%b expected a=00 b=00", fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (ex_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_stall: got ex_valid=%b stall=%b expected 0 0", ex_valid, stall);
    end
    checks++;
    if (stall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", stall_count);
    end
    repeat (2) tick();
    #2 reset_n = 1'b1;
    tick();
  endtask

  // ADD r3,r1,r2 ; SUB r5,r3,r3
  task automatic test_back_to_back();
    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall: got %b expected 0", stall);
    end
    tick();
    checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
      errors++;
      $display("FAIL b2b_sel: got a=%b b=%b expected a=10 b=10", fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ex_valid: got %b expected 1", ex_valid);
    end
  endtask

  // ADD r3 ; NOP ; OR r6,r3,r1   then   ADD r3 ; XOR r3 ; OR r6,r3,r1
  task automatic test_mem_forward();
    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL memfwd_sel: got a=%b b=%b expected a=01 b=00", fwd_a_sel, fwd_b_sel);
    end

    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL newest_wins_sel: got a=%b b=%b expected a=10 b=00", fwd_a_sel, fwd_b_sel);
    end
  endtask

  // LW r4,0(r1) ; ADD r7,r4,r2
  task automatic test_load_use();
    drain();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_stall: got %b expected 1", stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL loaduse_bubble: got ex_valid=%b a=%b b=%b expected 0 00 00",
               ex_valid, fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_stall_once: got %b expected 0", stall);
    end
    checks++;
    if (stall_count !== (CntOn ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL loaduse_count: got %0d expected %0d", stall_count, CntOn ? 1 : 0);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL loaduse_fwd: got ex_valid=%b a=%b b=%b expected 1 01 00",
               ex_valid, fwd_a_sel, fwd_b_sel);
    end
  endtask

  // ADD r0 ; SUB r5,r0,r0   and   LW r0 ; ADD r7,r0,r2
  task automatic test_r0();
    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL r0_alu_sel: got a=%b b=%b expected a=00 b=00", fwd_a_sel, fwd_b_sel);
    end

    drain();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL r0_load_stall: got %b expected 0", stall);
    end
    tick();
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL r0_load_sel: got a=%b b=%b ex_valid=%b expected 00 00 1",
               fwd_a_sel, fwd_b_sel, ex_valid);
    end
  endtask

  task automatic test_freeze();
    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    // SUB waits in ID while the pipeline is frozen with ADD in EX.
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || ex_valid !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold_a[%0d]: got a=%b b=%b ex_valid=%b expected 00 00 1",
                 i, fwd_a_sel, fwd_b_sel, ex_valid);
      end
    end
    freeze = 1'b0;
    tick();
    checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
      errors++;
      $display("FAIL freeze_release: got a=%b b=%b expected a=10 b=10", fwd_a_sel, fwd_b_sel);
    end
    // OR r6,r7,r8 has no in-flight producer; selects for SUB must hold while frozen.
    drive(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10 || ex_valid !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold_b[%0d]: got a=%b b=%b ex_valid=%b expected 10 10 1",
                 i, fwd_a_sel, fwd_b_sel, ex_valid);
      end
    end
    freeze = 1'b0;
    tick();
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL freeze_next: got a=%b b=%b expected a=00 b=00", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_flush();
    drain();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b expected 0", stall);
    end
    tick();
    flush = 1'b0;
    nop();
    checks++;
    if (ex_valid !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL flush_bubble: got ex_valid=%b a=%b b=%b expected 0 00 00",
               ex_valid, fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (stall_count !== (CntOn ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL flush_count: got %0d expected %0d", stall_count, CntOn ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid_run();
    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    checks++;
    if (fwd_a_sel !== 2'b10 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got a=%b ex_valid=%b expected 10 1", fwd_a_sel, ex_valid);
    end
    drive(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_stall: got %b expected 1", stall);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL midrst_async: got stall=%b ex_valid=%b a=%b b=%b expected 0 0 00 00",
               stall, ex_valid, fwd_a_sel, fwd_b_sel);
    end
    checks++;
    if (stall_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_count: got %0d expected 0", stall_count);
    end
    tick();
    #2 reset_n = 1'b1;
    // SUB r5,r3,r3: the pre-reset ADD r3 must be gone.
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_first_sel: got a=%b b=%b ex_valid=%b expected 00 00 1",
               fwd_a_sel, fwd_b_sel, ex_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_back_to_back();
    test_mem_forward();
    test_load_use();
    test_r0();
    test_freeze();
    test_flush();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
